uart_rx_param: RTL and testbench

Parametrised UART receiver: next generation of the fixed-format receiver in the VU-meter front end. It converts the asynchronous `rx` line into parallel words with a configurable frame format: data width, parity mode, stop-bit count and oversampling ratio. Each received sample is held in an output register with a valid/ready handshake toward the level-processing logic, and framing, parity and overrun errors are reported separately.

---
 rtl/uart_rx_param.sv | 100 ++++++++++
 tb/tb_uart_rx_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable frame format and valid/ready output.
module uart_rx_param #(
  parameter int freq_in     = 100_000_000,
  parameter int uart_freq   = 115_200,
  parameter int oversample  = 16,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [data_bits-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 format_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int DIV = freq_in / (uart_freq * oversample);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int OW = $clog2(oversample);
  localparam int BW = $clog2(data_bits);
  localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);
  localparam logic [OW-1:0] T_S0 = OW'(oversample / 2 - 1);
  localparam logic [OW-1:0] T_S1 = OW'(oversample / 2);
  localparam logic [OW-1:0] T_S2 = OW'(oversample / 2 + 1);
  localparam logic [OW-1:0] T_END = OW'(oversample - 1);
  localparam logic [BW-1:0] B_END = BW'(data_bits - 1);
  localparam logic S_END = 1'(stop_bits - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;
  state_t r_state, w_next;
  logic r_s1, r_s2, r_s3, r_m0, r_m1, r_pbit, r_ferr, r_scnt;
  logic [DW-1:0] r_div;
  logic [OW-1:0] r_tcnt;
  logic [BW-1:0] r_bit;
  logic [data_bits-1:0] r_shift;
  logic w_tick, w_start, w_dec, w_bit, w_pexp, w_perr, w_ferr, w_done, w_good, w_load;
  assign w_tick  = r_div == DIV_END;
  assign w_start = (r_state == S_IDLE) & r_s3 & ~r_s2;
  assign w_dec   = w_tick & (r_tcnt == T_S2);
  assign w_bit   = (r_m0 & r_m1) | (r_m0 & r_s2) | (r_m1 & r_s2);
  assign w_pexp  = (^r_shift) ^ (parity_mode == 2);
  assign w_perr  = (parity_mode != 0) && (r_pbit != w_pexp);
  assign w_ferr  = r_ferr | ~w_bit;
  assign w_done  = (r_state == S_STOP) & w_dec & (r_scnt == S_END);
  assign w_good  = w_done & ~w_ferr & ~w_perr;
  assign w_load  = w_good & ~(data_valid & ~data_ready);
  assign busy    = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = w_start ? S_START : S_IDLE;
      S_START:  w_next = w_dec ? (w_bit ? S_IDLE : S_DATA) : S_START;
      S_DATA:   w_next = (w_dec && r_bit == B_END) ? (parity_mode != 0 ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY: w_next = w_dec ? S_STOP : S_PARITY;
      S_STOP:   w_next = w_done ? (w_ferr ? S_WAIT : S_IDLE) : S_STOP;
      S_WAIT:   w_next = r_s2 ? S_IDLE : S_WAIT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s1, r_s2, r_s3} <= 3'b111;
      {r_m0, r_m1, r_pbit, r_ferr, r_scnt} <= '0;
      r_div <= '0;
      r_tcnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      data_out <= '0;
      {data_valid, format_err, parity_err, overrun_err} <= '0;
    end else begin
      {r_s1, r_s2, r_s3} <= {rx, r_s1, r_s2};
      r_div <= (w_start | w_tick) ? '0 : r_div + 1'b1;
      r_tcnt <= w_start ? '0 : w_tick ? (r_tcnt == T_END ? '0 : r_tcnt + 1'b1) : r_tcnt;
      if (w_tick && r_tcnt == T_S0) r_m0 <= r_s2;
      if (w_tick && r_tcnt == T_S1) r_m1 <= r_s2;
      if (w_start) {r_bit, r_scnt, r_ferr} <= '0;
      if (w_dec && r_state == S_DATA) begin
        r_shift <= {w_bit, r_shift[data_bits-1:1]};
        r_bit <= r_bit + 1'b1;
      end
      if (w_dec && r_state == S_PARITY) r_pbit <= w_bit;
      if (w_dec && r_state == S_STOP) begin
        r_scnt <= r_scnt + 1'b1;
        r_ferr <= w_ferr;
      end
      format_err <= w_done & w_ferr;
      parity_err <= w_done & w_perr;
      overrun_err <= w_good & data_valid & ~data_ready;
      data_valid <= w_load | (data_valid & ~data_ready);
      if (w_load) data_out <= r_shift;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames into 8N1 and 8E1 receivers, checked against a frame-level model.
module tb_uart_rx_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic rx [2] = '{1'b1, 1'b1};
  logic rdy [2] = '{1'b1, 1'b1};
  logic [7:0] dout [2];
  logic dv [2], fe [2], pe [2], ov [2], bsy [2];
  uart_rx_param #(.freq_in(64), .uart_freq(1), .oversample(16), .data_bits(8), .parity_mode(0), .stop_bits(1)) u_n (
    .clk(clk), .rst(rst), .rx(rx[0]), .data_out(dout[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
    .format_err(fe[0]), .parity_err(pe[0]), .overrun_err(ov[0]), .busy(bsy[0]));
  uart_rx_param #(.freq_in(64), .uart_freq(1), .oversample(16), .data_bits(8), .parity_mode(1), .stop_bits(1)) u_e (
    .clk(clk), .rst(rst), .rx(rx[1]), .data_out(dout[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
    .format_err(fe[1]), .parity_err(pe[1]), .overrun_err(ov[1]), .busy(bsy[1]));
  int n_fe [2], n_pe [2], n_ov [2], n_dv [2];
  int n_bad_busy = 0;
  logic [7:0] last [2];
  time t_dv [2], t_st [2];
  logic dv_q [2] = '{1'b0, 1'b0};
  logic bsy_q [2] = '{1'b0, 1'b0};
  int n_chk = 0, n_fail = 0;
  int b_fe, b_pe, b_ov, b_dv;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fe[i]) n_fe[i]++;
      if (pe[i]) n_pe[i]++;
      if (ov[i]) n_ov[i]++;
      if (dv[i] && !dv_q[i]) begin
        n_dv[i]++;
        last[i] = dout[i];
        t_dv[i] = $time;
        if (bsy[i] || !bsy_q[i]) n_bad_busy++;
      end
      dv_q[i] = dv[i];
      bsy_q[i] = bsy[i];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  task automatic snap(input int ch);
    b_fe = n_fe[ch];
    b_pe = n_pe[ch];
    b_ov = n_ov[ch];
    b_dv = n_dv[ch];
  endtask
  task automatic check_deltas(input string tag, input int ch, input int efe, input int epe, input int eov, input int edv);
    check({tag, " format_err"}, n_fe[ch] - b_fe, efe);
    check({tag, " parity_err"}, n_pe[ch] - b_pe, epe);
    check({tag, " overrun_err"}, n_ov[ch] - b_ov, eov);
    check({tag, " words"}, n_dv[ch] - b_dv, edv);
  endtask
  task automatic send_frame(input int ch, input logic [7:0] d, input bit has_p, input logic pb, input logic stp);
    logic q [$];
    q.push_back(1'b0);
    for (int j = 0; j < 8; j++) q.push_back(d[j]);
    if (has_p) q.push_back(pb);
    q.push_back(stp);
    @(posedge clk);
    t_st[ch] = $time;
    foreach (q[j]) begin
      rx[ch] = q[j];
      wait_clk(64);
    end
  endtask
  task automatic idle(input int ch, input int n);
    rx[ch] = 1'b1;
    wait_clk(n);
  endtask
  initial begin
    int ch;
    logic [7:0] d;
    logic stp, pb;
    int efe, epe, edv;
    wait_clk(4);
    settle();
    for (int i = 0; i < 2; i++) begin
      check("reset data_out", dout[i], 0);
      check("reset flags", {dv[i], fe[i], pe[i], ov[i], bsy[i]}, 0);
    end
    rst = 1'b0;
    wait_clk(8);
    snap(0);
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    idle(0, 16);
    settle();
    check_deltas("8N1 0x55", 0, 0, 0, 0, 1);
    check("8N1 0x55 data", last[0], 8'h55);
    check("8N1 valid in stop bit", (t_dv[0] - t_st[0] >= 6080) && (t_dv[0] - t_st[0] <= 6240), 1);
    check("8N1 busy after", bsy[0], 0);
    check("8N1 valid consumed", dv[0], 0);
    snap(1);
    send_frame(1, 8'hA3, 1, 1'b1, 1'b1);
    idle(1, 16);
    settle();
    check_deltas("bad parity", 1, 0, 1, 0, 0);
    snap(1);
    send_frame(1, 8'hA3, 1, 1'b0, 1'b1);
    idle(1, 16);
    settle();
    check_deltas("good parity", 1, 0, 0, 0, 1);
    check("good parity data", last[1], 8'hA3);
    snap(0);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
    wait_clk(640);
    settle();
    check("break busy", bsy[0], 1);
    check("break format_err", n_fe[0] - b_fe, 1);
    idle(0, 64);
    settle();
    check("break released busy", bsy[0], 0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    idle(0, 16);
    settle();
    check_deltas("after break", 0, 1, 0, 0, 1);
    check("after break data", last[0], 8'h3C);
    snap(0);
    @(posedge clk);
    rx[0] = 1'b0;
    wait_clk(16);
    #1;
    check("glitch busy", bsy[0], 1);
    rx[0] = 1'b1;
    wait_clk(36);
    settle();
    check("glitch busy cleared", bsy[0], 0);
    idle(0, 64);
    settle();
    check_deltas("glitch", 0, 0, 0, 0, 0);
    rdy[0] = 1'b0;
    snap(0);
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    idle(0, 16);
    settle();
    check("hold data", dout[0], 8'h11);
    check("hold valid", dv[0], 1);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    idle(0, 16);
    settle();
    check_deltas("overrun", 0, 0, 0, 1, 1);
    check("overrun keeps data", dout[0], 8'h11);
    check("overrun keeps valid", dv[0], 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("consume clears valid", dv[0], 0);
    rdy[0] = 1'b1;
    snap(0);
    fork
      send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
      begin
        wait_clk(1 + 64 * 4 + 32);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe reset data_out", dout[0], 0);
        check("midframe reset flags", {dv[0], fe[0], pe[0], ov[0], bsy[0]}, 0);
        rst = 1'b0;
      end
    join
    idle(0, 32);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    idle(0, 16);
    settle();
    check_deltas("after reset", 0, 0, 0, 0, 1);
    check("after reset data", last[0], 8'h81);
    for (int k = 0; k < 12; k++) begin
      ch = k % 2;
      d = 8'($urandom);
      stp = $urandom_range(3) != 0;
      pb = (^d) ^ ($urandom_range(3) == 0);
      efe = stp ? 0 : 1;
      epe = (ch == 1 && pb != ^d) ? 1 : 0;
      edv = (efe == 0 && epe == 0) ? 1 : 0;
      snap(ch);
      send_frame(ch, d, ch == 1, pb, stp);
      idle(ch, 32);
      settle();
      check_deltas($sformatf("random %0d", k), ch, efe, epe, 0, edv);
      if (edv == 1) check($sformatf("random %0d data", k), last[ch], d);
    end
    check("busy falls with valid", n_bad_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
